// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, one bit per clock, LSB first.
// Handles operand loading, carry storage, bit counting, result capture and handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MSB_IN = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, psum;
    logic             c_q, c_msb;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;

    assign fa_s = a_sh[0] ^ b_sh[0] ^ c_q;
    assign fa_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_q) | (b_sh[0] & c_q);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (abort) state_nx = IDLE;
                     else if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // busy/done are registered decodes of the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN);
            done  <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            c_q   <= 1'b0;
            c_msb <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= op_a;
                        b_sh <= op_b;
                        c_q  <= cin;
                        cnt  <= '0;
                        psum <= '0;
                    end
                end
                RUN: begin
                    if (!abort) begin
                        psum <= {fa_s, psum[WIDTH-1:1]};
                        a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                        c_q  <= fa_c;
                        cnt  <= cnt + 1'b1;
                        if (cnt == MSB_IN) c_msb <= fa_c;
                        if (cnt == LAST) begin
                            sum  <= {fa_s, psum[WIDTH-1:1]};
                            cout <= fa_c;
                            ovf  <= fa_c ^ c_msb;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: timeline-based reference model plus
// directed literal cases and a randomised sweep.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int vectors = 0;
    int fails = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation accepted at edge number acc completes at
    // edge acc+W unless aborted; done is high only after that completion edge.
    int           n = 0;
    int           acc = -100;
    int           done_edge = -100;
    bit           inop = 1'b0;
    logic [W-1:0] pa = '0, pb = '0;
    logic         pc = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0, m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; acc = -100; done_edge = -100; inop = 1'b0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else begin
            n++;
            if (inop) begin
                if (abort) inop = 1'b0;
                else if (n == acc + W) begin
                    {m_cout, m_sum} = {1'b0, pa} + {1'b0, pb} + {{W{1'b0}}, pc};
                    m_ovf = (pa[W-1] == pb[W-1]) && (m_sum[W-1] != pa[W-1]);
                    inop = 1'b0;
                    done_edge = n;
                end
            end else if (start && n != done_edge + 1) begin
                inop = 1'b1; acc = n; pa = op_a; pb = op_b; pc = cin;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, inop);
        chk("done", done, (n == done_edge) && rst_n);
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
        chk("ovf", ovf, m_ovf);
    end

    task automatic wait_idle();
        int g = 0;
        while ((busy || done) && g < 50) begin @(negedge clk); g++; end
        chk("idle_timeout", g < 50, 1);
    endtask

    // Accept one addition and check latency, busy length and literal results.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic eco, input logic eov,
                          input bit scramble);
        int cyc = 0;
        int bcnt = 0;
        wait_idle();
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (busy) bcnt++;
        while (!done && cyc < 40) begin
            if (scramble) begin
                op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
                start = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        chk("done_latency", cyc, W);
        chk("busy_cycles", bcnt, W);
        chk("res_sum", sum, es);
        chk("res_cout", cout, eco);
        chk("res_ovf", ovf, eov);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rs;
        logic         rc, rco, rov;
        int           dcnt;

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_add(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_add(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Requests while busy and while done must be ignored.
        wait_idle();
        op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int j = 1; j <= 16; j++) begin
            if (j == 2 || j == 8) begin op_a = 8'hFF; op_b = 8'hFF; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("ign_done_count", dcnt, 1);
        chk("ign_sum", sum, 8'h46);
        chk("ign_busy", busy, 0);

        // Abort mid-RUN keeps the previous result.
        do_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        op_a = 8'h10; op_b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        dcnt = 0;
        repeat (12) begin @(negedge clk); if (done) dcnt++; end
        chk("abort_no_done", dcnt, 0);
        chk("abort_sum", sum, 8'h02);
        chk("abort_cout", cout, 0);

        // Asynchronous reset between edges in the middle of an operation.
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            {rco, rs} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            rov = (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]);
            do_add(ra, rb, rc, rs, rco, rov, 1'b1);
        end

        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
